// File: rtl/rv32_exec_stage.sv
// rv32_exec_stage: RV32I execute slice -- instruction decode, ALU operand
// selection and ALU, with the ALU result, zero flag and writeback enable
// registered (one-cycle latency).
//
// Ports
//   clk_i       clock; all state updates on posedge
//   rst_ni      asynchronous active-low reset
//   instr_i     instruction word (opcode [6:0], funct3 [14:12], funct7 bit [30])
//   pc_i        PC of instr_i
//   src1_i      rs1 value
//   src2_i      rs2 value
//   imm_i       decoded, sign-extended immediate
//   op_imm_o    immediate format 0=I 1=S 2=B 3=U 4=J (combinational)
//   en_wmem_o   store (combinational)
//   branch_o    JAL/JALR/BRANCH (combinational)
//   load_o      LOAD (combinational)
//   alu_sel_o   ALU operation (combinational)
//   result_o    registered ALU result
//   is_zero_o   registered (result == 0)
//   wb_en_o     registered register-writeback enable
module rv32_exec_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  input  logic [XLEN-1:0] imm_i,
  output logic [2:0]      op_imm_o,
  output logic            en_wmem_o,
  output logic            branch_o,
  output logic            load_o,
  output logic [3:0]      alu_sel_o,
  output logic [XLEN-1:0] result_o,
  output logic            is_zero_o,
  output logic            wb_en_o
);

  localparam int unsigned SHW = 5;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_PASS = 4'b1111;

  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_S = 3'd1;
  localparam logic [2:0] FMT_B = 3'd2;
  localparam logic [2:0] FMT_U = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;

  typedef struct packed {
    logic [3:0] alu_sel;
    logic       asrc;     // 0: src1, 1: pc
    logic [1:0] bsrc;     // 00/11: src2, 01: imm, 10: constant 4
    logic [2:0] op_imm;
    logic       en_wreg;
    logic       en_wmem;
    logic       branch;
    logic       load;
  } ctrl_t;

  ctrl_t           ctrl_c;
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic            f7;
  logic [XLEN-1:0] a_c;
  logic [XLEN-1:0] b_c;
  logic [XLEN-1:0] alu_c;
  logic [XLEN-1:0] result_d;
  logic            is_zero_d;
  logic            wb_en_d;

  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[30];

  // Control unit: purely combinational decode of the opcode.
  always_comb begin
    ctrl_c = '0;
    ctrl_c.alu_sel = ALU_ADD;
    unique case (opcode)
      7'b0110011: begin
        ctrl_c.alu_sel = {f7, f3};
        ctrl_c.en_wreg = 1'b1;
      end
      7'b0010011: begin
        // funct7 only distinguishes SRLI/SRAI; elsewhere bit 30 is immediate data
        ctrl_c.alu_sel = {(f3 == 3'b101) ? f7 : 1'b0, f3};
        ctrl_c.bsrc    = 2'b01;
        ctrl_c.op_imm  = FMT_I;
        ctrl_c.en_wreg = 1'b1;
      end
      7'b0110111: begin
        ctrl_c.alu_sel = ALU_PASS;
        ctrl_c.bsrc    = 2'b01;
        ctrl_c.op_imm  = FMT_U;
        ctrl_c.en_wreg = 1'b1;
      end
      7'b0010111: begin
        ctrl_c.asrc    = 1'b1;
        ctrl_c.bsrc    = 2'b01;
        ctrl_c.op_imm  = FMT_U;
        ctrl_c.en_wreg = 1'b1;
      end
      7'b1101111: begin
        ctrl_c.asrc    = 1'b1;
        ctrl_c.bsrc    = 2'b10;
        ctrl_c.op_imm  = FMT_J;
        ctrl_c.en_wreg = 1'b1;
        ctrl_c.branch  = 1'b1;
      end
      7'b1100111: begin
        ctrl_c.asrc    = 1'b1;
        ctrl_c.bsrc    = 2'b10;
        ctrl_c.op_imm  = FMT_I;
        ctrl_c.en_wreg = 1'b1;
        ctrl_c.branch  = 1'b1;
      end
      7'b1100011: begin
        // Compare result feeds branch resolution downstream
        unique case (f3[2:1])
          2'b10:   ctrl_c.alu_sel = ALU_SLT;
          2'b11:   ctrl_c.alu_sel = ALU_SLTU;
          default: ctrl_c.alu_sel = ALU_SUB;
        endcase
        ctrl_c.op_imm = FMT_B;
        ctrl_c.branch = 1'b1;
      end
      7'b0000011: begin
        ctrl_c.bsrc    = 2'b01;
        ctrl_c.op_imm  = FMT_I;
        ctrl_c.load    = 1'b1;
        ctrl_c.en_wreg = 1'b1;
      end
      7'b0100011: begin
        ctrl_c.bsrc    = 2'b01;
        ctrl_c.op_imm  = FMT_S;
        ctrl_c.en_wmem = 1'b1;
      end
      default: ;
    endcase
  end

  assign op_imm_o  = ctrl_c.op_imm;
  assign en_wmem_o = ctrl_c.en_wmem;
  assign branch_o  = ctrl_c.branch;
  assign load_o    = ctrl_c.load;
  assign alu_sel_o = ctrl_c.alu_sel;

  // Operand muxes
  always_comb begin
    a_c = ctrl_c.asrc ? pc_i : src1_i;
    unique case (ctrl_c.bsrc)
      2'b01:   b_c = imm_i;
      2'b10:   b_c = XLEN'(4);
      default: b_c = src2_i;
    endcase
  end

  // ALU; unassigned selector codes produce zero
  always_comb begin
    alu_c = '0;
    unique case (ctrl_c.alu_sel)
      ALU_ADD:  alu_c = a_c + b_c;
      ALU_SUB:  alu_c = a_c - b_c;
      ALU_SLL:  alu_c = a_c << b_c[SHW-1:0];
      ALU_SLT:  alu_c = XLEN'($signed(a_c) < $signed(b_c));
      ALU_SLTU: alu_c = XLEN'(a_c < b_c);
      ALU_XOR:  alu_c = a_c ^ b_c;
      ALU_SRL:  alu_c = a_c >> b_c[SHW-1:0];
      ALU_SRA:  alu_c = XLEN'($signed(a_c) >>> b_c[SHW-1:0]);
      ALU_OR:   alu_c = a_c | b_c;
      ALU_AND:  alu_c = a_c & b_c;
      ALU_PASS: alu_c = b_c;
      default:  alu_c = '0;
    endcase
  end

  assign result_d  = alu_c;
  assign is_zero_d = (alu_c == '0);
  assign wb_en_d   = ctrl_c.en_wreg;

  // Output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_o  <= '0;
      is_zero_o <= 1'b0;
      wb_en_o   <= 1'b0;
    end else begin
      result_o  <= result_d;
      is_zero_o <= is_zero_d;
      wb_en_o   <= wb_en_d;
    end
  end

endmodule

// File: tb/tb_rv32_exec_stage.sv
// Directed testbench for rv32_exec_stage.
module tb_rv32_exec_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr, pc, src1, src2, imm;
  logic [2:0]  op_imm;
  logic        en_wmem, branch, load;
  logic [3:0]  alu_sel;
  logic [31:0] result;
  logic        is_zero, wb_en;

  int total = 0;
  int bad   = 0;

  rv32_exec_stage dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .instr_i   (instr),
    .pc_i      (pc),
    .src1_i    (src1),
    .src2_i    (src2),
    .imm_i     (imm),
    .op_imm_o  (op_imm),
    .en_wmem_o (en_wmem),
    .branch_o  (branch),
    .load_o    (load),
    .alu_sel_o (alu_sel),
    .result_o  (result),
    .is_zero_o (is_zero),
    .wb_en_o   (wb_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one instruction; caller is #1 past a posedge
  task automatic drive(input logic [31:0] i, p, s1, s2, im);
    instr = i; pc = p; src1 = s1; src2 = s2; imm = im;
    #1;
  endtask

  task automatic clock_in();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(32'h00000033, 32'h0, 32'd5, 32'd7, 32'h0);
    total++;
    if (result !== 32'h0 || is_zero !== 1'b0 || wb_en !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got result=%h is_zero=%b wb_en=%b want 0/0/0", result, is_zero, wb_en);
    end
    clock_in();
    total++;
    if (result !== 32'h0 || wb_en !== 1'b0) begin
      bad++;
      $display("FAIL reset_held_on_clk: got result=%h wb_en=%b want 0/0", result, wb_en);
    end
    rst_n = 1'b1;
    clock_in();
  endtask

  task automatic test_op();
    drive(32'h00000033, 32'h0, 32'd5, 32'd7, 32'h0);
    total++;
    if (alu_sel !== 4'b0000 || op_imm !== 3'd0 || branch !== 1'b0 || load !== 1'b0 || en_wmem !== 1'b0) begin
      bad++;
      $display("FAIL add_ctrl: got sel=%b op_imm=%0d br=%b ld=%b st=%b want 0000/0/0/0/0", alu_sel, op_imm, branch, load, en_wmem);
    end
    clock_in();
    total++;
    if (result !== 32'd12 || wb_en !== 1'b1 || is_zero !== 1'b0) begin
      bad++;
      $display("FAIL add: got result=%h wb_en=%b is_zero=%b want 0000000c/1/0", result, wb_en, is_zero);
    end
    drive(32'h40000033, 32'h0, 32'd9, 32'd9, 32'h0);
    clock_in();
    total++;
    if (result !== 32'h0 || is_zero !== 1'b1 || wb_en !== 1'b1) begin
      bad++;
      $display("FAIL sub_zero: got result=%h is_zero=%b wb_en=%b want 0/1/1", result, is_zero, wb_en);
    end
    // f7=1 with f3=001 is an unassigned ALU code
    drive(32'h40001033, 32'h0, 32'h1234, 32'h3, 32'h0);
    clock_in();
    total++;
    if (result !== 32'h0 || is_zero !== 1'b1) begin
      bad++;
      $display("FAIL invalid_sel: got result=%h is_zero=%b want 0/1", result, is_zero);
    end
    // XOR / SLL / OR / AND through R-type
    drive(32'h00004033, 32'h0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h0);
    clock_in();
    total++;
    if (result !== 32'hFF00_EDCB) begin
      bad++;
      $display("FAIL xor: got %h want ff00edcb", result);
    end
    drive(32'h00001033, 32'h0, 32'h0000_0003, 32'h0000_0024, 32'h0);
    clock_in();
    total++;
    if (result !== 32'h0000_0030) begin
      bad++;
      $display("FAIL sll_b40: got %h want 00000030", result);
    end
  endtask

  task automatic test_op_imm();
    drive(32'h40005013, 32'h0, 32'h8000_0000, 32'h0, 32'h0000_0404);
    total++;
    if (alu_sel !== 4'b1101 || op_imm !== 3'd0) begin
      bad++;
      $display("FAIL srai_ctrl: got sel=%b op_imm=%0d want 1101/0", alu_sel, op_imm);
    end
    clock_in();
    total++;
    if (result !== 32'hF800_0000 || wb_en !== 1'b1) begin
      bad++;
      $display("FAIL srai: got result=%h wb_en=%b want f8000000/1", result, wb_en);
    end
    drive(32'h00005013, 32'h0, 32'h8000_0000, 32'h0, 32'h0000_0404);
    clock_in();
    total++;
    if (result !== 32'h0800_0000) begin
      bad++;
      $display("FAIL srli: got %h want 08000000", result);
    end
    // ADDI with bit 30 set in the immediate must still add, not subtract
    drive(32'h40000013, 32'h0, 32'd10, 32'd99, 32'h0000_0400);
    total++;
    if (alu_sel !== 4'b0000) begin
      bad++;
      $display("FAIL addi_sel: got %b want 0000", alu_sel);
    end
    clock_in();
    total++;
    if (result !== 32'h0000_040A) begin
      bad++;
      $display("FAIL addi: got %h want 0000040a", result);
    end
  endtask

  task automatic test_jump_upper();
    drive(32'h0000006F, 32'h8000_0000, 32'h5, 32'h6, 32'h100);
    total++;
    if (branch !== 1'b1 || op_imm !== 3'd4 || alu_sel !== 4'b0000) begin
      bad++;
      $display("FAIL jal_ctrl: got br=%b op_imm=%0d sel=%b want 1/4/0000", branch, op_imm, alu_sel);
    end
    clock_in();
    total++;
    if (result !== 32'h8000_0004 || wb_en !== 1'b1) begin
      bad++;
      $display("FAIL jal: got result=%h wb_en=%b want 80000004/1", result, wb_en);
    end
    drive(32'h00000067, 32'h0000_1000, 32'h5, 32'h6, 32'h100);
    total++;
    if (branch !== 1'b1 || op_imm !== 3'd0) begin
      bad++;
      $display("FAIL jalr_ctrl: got br=%b op_imm=%0d want 1/0", branch, op_imm);
    end
    clock_in();
    total++;
    if (result !== 32'h0000_1004) begin
      bad++;
      $display("FAIL jalr: got %h want 00001004", result);
    end
    drive(32'h00000017, 32'h8000_0000, 32'h5, 32'h6, 32'h0000_1000);
    total++;
    if (op_imm !== 3'd3 || branch !== 1'b0) begin
      bad++;
      $display("FAIL auipc_ctrl: got op_imm=%0d br=%b want 3/0", op_imm, branch);
    end
    clock_in();
    total++;
    if (result !== 32'h8000_1000) begin
      bad++;
      $display("FAIL auipc: got %h want 80001000", result);
    end
    drive(32'h00000037, 32'h8000_0000, 32'h5, 32'h6, 32'h1234_5000);
    total++;
    if (alu_sel !== 4'b1111 || op_imm !== 3'd3) begin
      bad++;
      $display("FAIL lui_ctrl: got sel=%b op_imm=%0d want 1111/3", alu_sel, op_imm);
    end
    clock_in();
    total++;
    if (result !== 32'h1234_5000 || wb_en !== 1'b1) begin
      bad++;
      $display("FAIL lui: got result=%h wb_en=%b want 12345000/1", result, wb_en);
    end
  endtask

  task automatic test_mem();
    drive(32'h00000023, 32'h0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0010);
    total++;
    if (en_wmem !== 1'b1 || op_imm !== 3'd1 || load !== 1'b0) begin
      bad++;
      $display("FAIL store_ctrl: got st=%b op_imm=%0d ld=%b want 1/1/0", en_wmem, op_imm, load);
    end
    clock_in();
    total++;
    if (result !== 32'h0000_0110 || wb_en !== 1'b0) begin
      bad++;
      $display("FAIL store: got result=%h wb_en=%b want 00000110/0", result, wb_en);
    end
    drive(32'h00000003, 32'h0, 32'h0000_1000, 32'h0, 32'hFFFF_FFFC);
    total++;
    if (load !== 1'b1 || en_wmem !== 1'b0 || op_imm !== 3'd0) begin
      bad++;
      $display("FAIL load_ctrl: got ld=%b st=%b op_imm=%0d want 1/0/0", load, en_wmem, op_imm);
    end
    clock_in();
    total++;
    if (result !== 32'h0000_0FFC || wb_en !== 1'b1) begin
      bad++;
      $display("FAIL load: got result=%h wb_en=%b want 00000ffc/1", result, wb_en);
    end
  endtask

  task automatic test_branch();
    drive(32'h00004063, 32'h0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h40);
    total++;
    if (alu_sel !== 4'b0010 || op_imm !== 3'd2 || branch !== 1'b1) begin
      bad++;
      $display("FAIL blt_ctrl: got sel=%b op_imm=%0d br=%b want 0010/2/1", alu_sel, op_imm, branch);
    end
    clock_in();
    total++;
    if (result !== 32'h1 || wb_en !== 1'b0 || is_zero !== 1'b0) begin
      bad++;
      $display("FAIL blt: got result=%h wb_en=%b is_zero=%b want 1/0/0", result, wb_en, is_zero);
    end
    drive(32'h00006063, 32'h0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h40);
    clock_in();
    total++;
    if (result !== 32'h0 || is_zero !== 1'b1) begin
      bad++;
      $display("FAIL bltu: got result=%h is_zero=%b want 0/1", result, is_zero);
    end
    drive(32'h00001063, 32'h0, 32'd20, 32'd20, 32'h40);
    total++;
    if (alu_sel !== 4'b1000) begin
      bad++;
      $display("FAIL bne_sel: got %b want 1000", alu_sel);
    end
    clock_in();
    total++;
    if (is_zero !== 1'b1) begin
      bad++;
      $display("FAIL bne_zero: got is_zero=%b want 1", is_zero);
    end
  endtask

  task automatic test_unknown();
    drive(32'h0000007F, 32'h8000_0000, 32'h0000_0011, 32'h0000_0022, 32'h1000);
    total++;
    if (alu_sel !== 4'b0000 || op_imm !== 3'd0 || branch !== 1'b0 || load !== 1'b0 || en_wmem !== 1'b0) begin
      bad++;
      $display("FAIL unknown_ctrl: got sel=%b op_imm=%0d br=%b ld=%b st=%b want 0000/0/0/0/0", alu_sel, op_imm, branch, load, en_wmem);
    end
    clock_in();
    total++;
    if (result !== 32'h0000_0033 || wb_en !== 1'b0) begin
      bad++;
      $display("FAIL unknown: got result=%h wb_en=%b want 00000033/0", result, wb_en);
    end
  endtask

  task automatic test_back_to_back();
    drive(32'h00000033, 32'h0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0);
    clock_in();
    total++;
    if (result !== 32'h0 || is_zero !== 1'b1) begin
      bad++;
      $display("FAIL b2b_wrap: got result=%h is_zero=%b want 0/1", result, is_zero);
    end
    drive(32'h00007033, 32'h0, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0);
    clock_in();
    total++;
    if (result !== 32'h0F00_0F00 || is_zero !== 1'b0) begin
      bad++;
      $display("FAIL b2b_and: got result=%h is_zero=%b want 0f000f00/0", result, is_zero);
    end
    drive(32'h00006013, 32'h0, 32'h0000_00F0, 32'h0, 32'h0000_000F);
    clock_in();
    total++;
    if (result !== 32'h0000_00FF) begin
      bad++;
      $display("FAIL b2b_ori: got %h want 000000ff", result);
    end
    // hold: same inputs keep the same registered value
    clock_in();
    total++;
    if (result !== 32'h0000_00FF || wb_en !== 1'b1) begin
      bad++;
      $display("FAIL b2b_hold: got result=%h wb_en=%b want 000000ff/1", result, wb_en);
    end
  endtask

  task automatic test_midrun_reset();
    drive(32'h00000037, 32'h0, 32'h0, 32'h0, 32'hABCD_E000);
    clock_in();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (result !== 32'h0 || is_zero !== 1'b0 || wb_en !== 1'b0) begin
      bad++;
      $display("FAIL midrun_reset: got result=%h is_zero=%b wb_en=%b want 0/0/0", result, is_zero, wb_en);
    end
    rst_n = 1'b1;
    drive(32'h00000037, 32'h0, 32'h0, 32'h0, 32'h5555_0000);
    clock_in();
    total++;
    if (result !== 32'h5555_0000 || wb_en !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_load: got result=%h wb_en=%b want 55550000/1", result, wb_en);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    instr = '0; pc = '0; src1 = '0; src2 = '0; imm = '0;
    @(posedge clk); #1;
    test_reset();
    test_op();
    test_op_imm();
    test_jump_upper();
    test_mem();
    test_branch();
    test_unknown();
    test_back_to_back();
    test_midrun_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
